// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: machine word, opcode encoding and register specifier.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'ha,
    OP_STI  = 4'hb,
    OP_JMP  = 4'hc,
    OP_SHF  = 4'hd,
    OP_LEA  = 4'he,
    OP_TRAP = 4'hf
  } lc3b_opcode;

  // JSR/JSRR write the return address here.
  localparam lc3b_reg LC3B_LINK_REG = 3'b111;

endpackage

// File: rtl/ir_decode.sv
// Combinational field extraction for one LC-3b instruction word.
module ir_decode
  import lc3b_types::*;
(
  input  lc3b_word   word,
  input  logic       jssr_en,
  output lc3b_opcode opcode,
  output lc3b_reg    dest,
  output lc3b_reg    src1,
  output lc3b_reg    src2,
  output lc3b_word   offset6,
  output lc3b_word   off6,
  output lc3b_word   offset9,
  output lc3b_word   offset11,
  output lc3b_word   imm5,
  output lc3b_word   imm4,
  output lc3b_word   trap8,
  output logic       bit0,
  output logic       bit4,
  output logic       bit5,
  output logic       bit5l,
  output logic       bit11
);

  assign opcode   = lc3b_opcode'(word[15:12]);
  assign dest     = jssr_en ? LC3B_LINK_REG : word[11:9];
  assign src1     = word[8:6];
  assign src2     = word[2:0];

  // Word-addressed offsets are pre-shifted to byte offsets; trap vector is unsigned.
  assign offset6  = {{9{word[5]}}, word[5:0], 1'b0};
  assign off6     = {{10{word[5]}}, word[5:0]};
  assign offset9  = {{6{word[8]}}, word[8:0], 1'b0};
  assign offset11 = {{4{word[10]}}, word[10:0], 1'b0};
  assign imm5     = {{11{word[4]}}, word[4:0]};
  assign imm4     = {{12{word[3]}}, word[3:0]};
  assign trap8    = {7'b0, word[7:0], 1'b0};

  assign bit0     = word[0];
  assign bit4     = word[4];
  assign bit5     = word[5];
  assign bit5l    = word[5];
  assign bit11    = word[11];

endmodule

// File: rtl/ir_queue.sv
// Instruction-register queue between fetch and decode; presents the decoded head entry.
module ir_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  lc3b_word               in,
  input  lc3b_word               in_pc,
  output logic                   ready,
  input  logic                   advance,
  input  logic                   flush,
  input  logic                   jssr_en,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output lc3b_word               head_pc,
  output lc3b_opcode             opcode,
  output lc3b_reg                dest,
  output lc3b_reg                src1,
  output lc3b_reg                src2,
  output lc3b_word               offset6,
  output lc3b_word               off6,
  output lc3b_word               offset9,
  output lc3b_word               offset11,
  output lc3b_word               imm5,
  output lc3b_word               imm4,
  output lc3b_word               trap8,
  output logic                   bit0,
  output logic                   bit4,
  output logic                   bit5,
  output logic                   bit5l,
  output logic                   bit11
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  lc3b_word       mem_word [DEPTH];
  lc3b_word       mem_pc   [DEPTH];
  logic [PW-1:0]  head_ptr;
  logic [PW-1:0]  tail_ptr;
  logic           enq;
  logic           deq;
  lc3b_word       head_word;

  // Handshake: a load transfers on a rising edge only while ready=1 and an
  // advance retires only while valid=1; both flags come from count alone, so
  // neither depends combinationally on load/advance. Flush overrides both.
  assign ready = (count != FULL);
  assign valid = (count != '0);
  assign enq   = load & ready;
  assign deq   = advance & valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (enq) tail_ptr <= tail_ptr + PW'(1);
      if (deq) head_ptr <= head_ptr + PW'(1);
      if (enq && !deq)      count <= count + (PW + 1)'(1);
      else if (deq && !enq) count <= count - (PW + 1)'(1);
    end
  end

  // Storage is never cleared; stale entries are hidden by the valid mask below.
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      mem_word[tail_ptr] <= in;
      mem_pc[tail_ptr]   <= in_pc;
    end
  end

  assign head_word = valid ? mem_word[head_ptr] : '0;
  assign head_pc   = valid ? mem_pc[head_ptr]   : '0;

  ir_decode u_decode (
    .word     (head_word),
    .jssr_en  (jssr_en),
    .opcode   (opcode),
    .dest     (dest),
    .src1     (src1),
    .src2     (src2),
    .offset6  (offset6),
    .off6     (off6),
    .offset9  (offset9),
    .offset11 (offset11),
    .imm5     (imm5),
    .imm4     (imm4),
    .trap8    (trap8),
    .bit0     (bit0),
    .bit4     (bit4),
    .bit5     (bit5),
    .bit5l    (bit5l),
    .bit11    (bit11)
  );

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: decode table, directed queue sequences and randomized traffic vs a queue model.
module tb_ir_queue;
  import lc3b_types::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0;
  lc3b_word   in = '0;
  lc3b_word   in_pc = '0;
  logic       ready;
  logic       advance = 1'b0;
  logic       flush = 1'b0;
  logic       jssr_en = 1'b0;
  logic       valid;
  logic [2:0] count;
  lc3b_word   head_pc;
  lc3b_opcode opcode;
  lc3b_reg    dest, src1, src2;
  lc3b_word   offset6, off6, offset9, offset11, imm5, imm4, trap8;
  logic       bit0, bit4, bit5, bit5l, bit11;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  ir_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .in(in), .in_pc(in_pc),
    .ready(ready), .advance(advance), .flush(flush), .jssr_en(jssr_en),
    .valid(valid), .count(count), .head_pc(head_pc), .opcode(opcode),
    .dest(dest), .src1(src1), .src2(src2), .offset6(offset6), .off6(off6),
    .offset9(offset9), .offset11(offset11), .imm5(imm5), .imm4(imm4),
    .trap8(trap8), .bit0(bit0), .bit4(bit4), .bit5(bit5), .bit5l(bit5l),
    .bit11(bit11)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic        jssr;
    int          op, dst, s1, s2, i5, off9, trap;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  function automatic int m16(input int v);
    return v & 'hffff;
  endfunction

  // Reference: entries are {pc, word}; the head is exp_q[0].
  task automatic check_head();
    int w, pc;
    bit v;
    v  = (exp_q.size() != 0);
    w  = v ? int'(exp_q[0][15:0]) : 0;
    pc = v ? int'(exp_q[0][31:16]) : 0;
    chk("count", count, exp_q.size());
    chk("valid", valid, v);
    chk("ready", ready, exp_q.size() < DEPTH);
    chk("head_pc", head_pc, pc);
    chk("opcode", opcode, (w >> 12) & 15);
    chk("dest", dest, jssr_en ? 7 : (w >> 9) & 7);
    chk("src1", src1, (w >> 6) & 7);
    chk("src2", src2, w & 7);
    chk("offset6", offset6, m16(sx(w & 63, 6) * 2));
    chk("off6", off6, m16(sx(w & 63, 6)));
    chk("offset9", offset9, m16(sx(w & 511, 9) * 2));
    chk("offset11", offset11, m16(sx(w & 2047, 11) * 2));
    chk("imm5", imm5, m16(sx(w & 31, 5)));
    chk("imm4", imm4, m16(sx(w & 15, 4)));
    chk("trap8", trap8, (w & 255) * 2);
    chk("bit0", bit0, w & 1);
    chk("bit4", bit4, (w >> 4) & 1);
    chk("bit5", bit5, (w >> 5) & 1);
    chk("bit5l", bit5l, (w >> 5) & 1);
    chk("bit11", bit11, (w >> 11) & 1);
  endtask

  task automatic model_step(input logic ld, input logic [15:0] w, input logic [15:0] pc,
                            input logic adv, input logic fl);
    bit can_enq, can_deq;
    can_enq = exp_q.size() < DEPTH;
    can_deq = exp_q.size() > 0;
    if (fl) exp_q.delete();
    else begin
      if (adv && can_deq) void'(exp_q.pop_front());
      if (ld && can_enq) exp_q.push_back({pc, w});
    end
  endtask

  task automatic cyc(input logic ld, input logic [15:0] w, input logic [15:0] pc,
                     input logic adv, input logic fl);
    load = ld; in = w; in_pc = pc; advance = adv; flush = fl;
    @(posedge clk);
    model_step(ld, w, pc, adv, fl);
    #1;
    load = 1'b0; advance = 1'b0; flush = 1'b0;
    check_head();
  endtask

  initial begin
    vecs[0] = '{16'h12bd, 1'b0, 1, 1, 2, 5, 'hfffd, 'h017a, 'h017a};
    vecs[1] = '{16'h40c0, 1'b1, 4, 7, 3, 0, 'h0000, 'h0180, 'h0180};
    vecs[2] = '{16'h40c0, 1'b0, 4, 0, 3, 0, 'h0000, 'h0180, 'h0180};
    vecs[3] = '{16'hf025, 1'b0, 15, 0, 0, 5, 'h0005, 'h004a, 'h004a};
    vecs[4] = '{16'h0fff, 1'b0, 0, 7, 7, 7, 'hffff, 'hfffe, 'h01fe};
    vecs[5] = '{16'h5a20, 1'b0, 5, 5, 0, 0, 'h0000, 'h0040, 'h0040};
    vecs[6] = '{16'h1270, 1'b1, 1, 7, 1, 0, 'hfff0, 'h00e0, 'h00e0};

    // Clock/reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 1);
    chk("rst_head_pc", head_pc, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_dest", dest, 0);
    chk("rst_imm5", imm5, 0);
    jssr_en = 1'b1;
    #1;
    chk("rst_dest_link", dest, 7);
    jssr_en = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_head();

    // Decode table: each word alone in the queue
    for (int i = 0; i < 7; i++) begin
      jssr_en = vecs[i].jssr;
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      cyc(1'b1, vecs[i].word, 16'h3000 + 16'(i * 2), 1'b0, 1'b0);
      chk("tbl_opcode", opcode, vecs[i].op);
      chk("tbl_dest", dest, vecs[i].dst);
      chk("tbl_src1", src1, vecs[i].s1);
      chk("tbl_src2", src2, vecs[i].s2);
      chk("tbl_imm5", imm5, vecs[i].i5);
      chk("tbl_offset9", offset9, vecs[i].off9);
      chk("tbl_trap8", trap8, vecs[i].trap);
      chk("tbl_head_pc", head_pc, 16'h3000 + 16'(i * 2));
    end
    jssr_en = 1'b0;

    // Trap then branch: advance exposes the second entry
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    cyc(1'b1, 16'hf025, 16'h3100, 1'b0, 1'b0);
    cyc(1'b1, 16'h0fff, 16'h3102, 1'b0, 1'b0);
    chk("seq_trap8", trap8, 'h004a);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("seq_offset9", offset9, 'hfffe);
    chk("seq_opcode_br", opcode, 0);

    // Fill to full, drop the fifth load, then load+advance when full
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 16'h1000 + 16'(i), 16'h4000 + 16'(i * 2), 1'b0, 1'b0);
      if (i == 3) chk("full_ready", ready, 0);
    end
    chk("full_count", count, 4);
    chk("full_head_pc", head_pc, 'h4000);
    cyc(1'b1, 16'h1777, 16'h4777, 1'b1, 1'b0);
    chk("full_ldadv_count", count, 3);
    chk("full_ldadv_head_pc", head_pc, 'h4002);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 16'($urandom), 16'h5000 + 16'(i * 2), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Empty queue: load+advance together, no bypass
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    cyc(1'b1, 16'h2345, 16'h6000, 1'b1, 1'b0);
    chk("empty_ldadv_count", count, 1);
    chk("empty_ldadv_head_pc", head_pc, 'h6000);

    // Flush wins over a same-cycle load
    cyc(1'b1, 16'h3456, 16'h6002, 1'b0, 1'b0);
    cyc(1'b1, 16'h4567, 16'h6004, 1'b0, 1'b1);
    chk("flush_count", count, 0);
    chk("flush_valid", valid, 0);
    chk("flush_src1", src1, 0);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 16'h7fff - 16'(i), 16'h7000 + 16'(i * 2), 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_valid", valid, 0);
    chk("async_count", count, 0);
    chk("async_ready", ready, 1);
    chk("async_head_pc", head_pc, 0);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_head();

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      jssr_en = 1'($urandom_range(0, 1));
      cyc(1'($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction-register queue for the LC-3b datapath. It sits between fetch and decode. It buffers up to DEPTH fetched instruction words, each with its PC. It presents the head entry's fully decoded fields (opcode, register specifiers, sign-extended offsets and immediates, control bits) to the control unit, so fetch can run ahead of execute. Flush support covers branch and trap redirects.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  enqueue request: write `in`/`in_pc` at tail
- in  in  lc3b_word  fetched instruction word
- in_pc  in  lc3b_word  PC of fetched word
- ready  out  1  queue not full (enqueue will be accepted)
- advance  in  1  dequeue request: retire head entry
- flush  in  1  discard all entries
- jssr_en  in  1  force `dest` to R7 (JSR/JSRR link)
- valid  out  1  head entry present
- count  out  $clog2(DEPTH)+1  occupied entries
- head_pc  out  lc3b_word  PC of head entry
- opcode  out  lc3b_opcode  head[15:12]
- dest, src1, src2  out  lc3b_reg  head[11:9] (or 3'b111 when jssr_en), head[8:6], head[2:0]
- offset6, off6, offset9, offset11, imm5, imm4, trap8  out  lc3b_word  head-field extensions
- bit0, bit4, bit5, bit5l, bit11  out  1  head[0], head[4], head[5], head[5], head[11]

## Operation
- Circular buffer: head pointer, tail pointer and count register. Pointers wrap modulo DEPTH.
- Enqueue is accepted when load=1 and ready=1. The word is written at the tail, and the tail and count increment.
- Enqueue with load=1 and ready=0 is dropped silently. Storage and count are unchanged.
- Dequeue is accepted when advance=1 and valid=1. The head and count advance.
- Dequeue with advance=1 and valid=0 is ignored.
- Simultaneous accepted enqueue and dequeue: both pointers move and count is unchanged.
  - When full, ready=0, so only the dequeue happens. There is no same-cycle refill.
  - When empty, only the enqueue happens. There is no bypass.
- flush=1 clears head, tail and count to 0 and has priority over load and advance in the same cycle. A load in a flush cycle is discarded.
- Decode applies to the head entry's word. When valid=0, the decoded word and head_pc are forced to 16'h0000. All field outputs then read 0, opcode reads BR, and dest reads 7 if jssr_en=1.
- Field extension rules (n = sign extension):
  - offset6 = n({h[5:0],0})
  - off6 = n(h[5:0])
  - offset9 = n({h[8:0],0})
  - offset11 = n({h[10:0],0})
  - imm5 = n(h[4:0])
  - imm4 = n(h[3:0])
  - trap8 = zero-extended {h[7:0],0}
- jssr_en acts combinationally on dest only. It is not stored per entry.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): pointers=0, count=0, valid=0, ready=1, head_pc=0, all decoded fields 0 (dest=7 iff jssr_en).
- Enqueue latency is 1 cycle. A word accepted at edge k is visible on the decode outputs after edge k when the queue was empty.
- Dequeue is effective at the edge. The next entry appears on the outputs after that edge.
- ready = (count != DEPTH); valid = (count != 0). Both are registered-state derived with no combinational path from load/advance.
- Decode outputs are combinational from head storage and jssr_en.
- Reset asserted mid-operation empties the queue immediately, without waiting for clk.
- Storage contents are not cleared by reset or flush. Only the pointers are reset, and the outputs are masked by valid.

## Structure
- lc3b_types holds lc3b_word, lc3b_opcode, lc3b_reg. Add a shared constant LC3B_LINK_REG = 3'b111 there.
- Sub-module ir_decode is combinational. It takes a word and jssr_en and produces all field outputs. ir_queue instantiates it once on the masked head word.
- Storage: DEPTH x (word + PC) register array with no reset on the array.

## Test plan
- Reset, then enqueue 0x12BD (ADD R1,R2,#-3) at PC 0x3000 → next cycle: valid=1, count=1, opcode=ADD, dest=1, src1=2, bit5=1, imm5=0xFFFD, head_pc=0x3000.
- Enqueue 0x40C0 (JSRR R3) with jssr_en=1 → dest=7, src1=3, bit11=0. Drop jssr_en → dest=0.
- Enqueue 0xF025, 0x0FFF, then advance once → head shows trap8=0x004A. After advance: offset9=0xFFFE, opcode=BR.
- DEPTH=4: five consecutive loads → ready=0 after the 4th, 5th dropped. Then load+advance together when full → only the dequeue happens, count=3. Wrap the pointers through 10 more pairs and check FIFO order.
- Empty queue with load+advance in the same cycle → count=1 and the head holds the new word. With count=2, flush+load → count=0, valid=0, outputs 0.
- Assert reset_n low between clock edges with count=3 → valid=0, count=0, ready=1 immediately.
